// File: rtl/popcount_tn_seq.sv
// Ternary-neuron sequencer: shares one external 8-input popcount unit across
// N_CHUNKS chunks (positive pass, then negative pass) and thresholds the difference.
// Optional build macro: POPCOUNT_TN_ZERO_SKIP_EN (all-zero operand chunks add 0).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// POS   | counting x & wp, one chunk per cycle, into acc_p
// NEG   | counting x & wn, one chunk per cycle, into acc_n
// RES   | out_valid high with stable sum/activation until out_ready

module popcount_tn_seq #(
   parameter int N_CHUNKS = 4,
   parameter int ACC_W    = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*N_CHUNKS-1:0]   in_x,
   input  logic [8*N_CHUNKS-1:0]   in_wp,
   input  logic [8*N_CHUNKS-1:0]   in_wn,
   input  logic [ACC_W:0]          thr_hi,
   input  logic [ACC_W:0]          thr_lo,
   output logic [7:0]              pc_a,
   input  logic [3:0]              pc_cnt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_act,
   output logic [ACC_W:0]          out_sum,
   output logic                    busy
);

   localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam int VEC_W = 8 * N_CHUNKS;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNKS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POS  = 2'd1,
      S_NEG  = 2'd2,
      S_RES  = 2'd3
   } state_t;

   state_t                   state;
   logic [IDX_W-1:0]         idx;
   logic [VEC_W-1:0]         x_q;
   logic [VEC_W-1:0]         wp_q;
   logic [VEC_W-1:0]         wn_q;
   logic signed [ACC_W:0]    thr_hi_q;
   logic signed [ACC_W:0]    thr_lo_q;
   logic [ACC_W-1:0]         acc_p;
   logic [ACC_W-1:0]         acc_n;

   logic [7:0]               x_chunk;
   logic [7:0]               wp_chunk;
   logic [7:0]               wn_chunk;
   logic [7:0]               operand;
   logic [ACC_W-1:0]         add_val;
   logic [ACC_W-1:0]         acc_n_nxt;
   logic signed [ACC_W:0]    sum_nxt;
   logic [1:0]               act_nxt;

   always_comb begin
      x_chunk  = x_q[int'(idx)*8 +: 8];
      wp_chunk = wp_q[int'(idx)*8 +: 8];
      wn_chunk = wn_q[int'(idx)*8 +: 8];
      operand  = 8'h00;
      case (state)
         S_POS:   operand = x_chunk & wp_chunk;
         S_NEG:   operand = x_chunk & wn_chunk;
         default: operand = 8'h00;
      endcase
   end

   assign pc_a = operand;

`ifdef POPCOUNT_TN_ZERO_SKIP_EN
   // Approximate units report a nonzero count for 8'h00; drop it.
   assign add_val = (operand == 8'h00) ? '0 : ACC_W'(pc_cnt);
`else
   assign add_val = ACC_W'(pc_cnt);
`endif

   // Final NEG cycle folds in the last count before the difference is taken.
   always_comb begin
      acc_n_nxt = acc_n + add_val;
      sum_nxt   = $signed({1'b0, acc_p}) - $signed({1'b0, acc_n_nxt});
      act_nxt   = 2'b00;
      if (sum_nxt >= thr_hi_q)
         act_nxt = 2'b01;
      else if (sum_nxt <= thr_lo_q)
         act_nxt = 2'b11;
   end

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         x_q       <= '0;
         wp_q      <= '0;
         wn_q      <= '0;
         thr_hi_q  <= '0;
         thr_lo_q  <= '0;
         acc_p     <= '0;
         acc_n     <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_act   <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x_q      <= in_x;
                  wp_q     <= in_wp;
                  wn_q     <= in_wn;
                  thr_hi_q <= thr_hi;
                  thr_lo_q <= thr_lo;
                  acc_p    <= '0;
                  acc_n    <= '0;
                  idx      <= '0;
                  state    <= S_POS;
               end
            end
            S_POS: begin
               acc_p <= acc_p + add_val;
               if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= S_NEG;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_NEG: begin
               acc_n <= acc_n_nxt;
               if (idx == IDX_LAST) begin
                  idx       <= '0;
                  out_sum   <= sum_nxt;
                  out_act   <= act_nxt;
                  out_valid <= 1'b1;
                  state     <= S_RES;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_RES: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_popcount_tn_seq.sv
// Directed bench for popcount_tn_seq with a behavioural popcount unit
// (exact, or with a bias of 2 for an all-zero operand).
`timescale 1ns/100ps

module tb_popcount_tn_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x;
   logic [31:0] in_wp;
   logic [31:0] in_wn;
   logic [6:0]  thr_hi;
   logic [6:0]  thr_lo;
   logic [7:0]  pc_a;
   logic [3:0]  pc_cnt;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_act;
   logic [6:0]  out_sum;
   logic        busy;

   logic        zero_bias;
   int          total;
   int          bad;

   popcount_tn_seq #(.N_CHUNKS(4), .ACC_W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_x     (in_x),
      .in_wp    (in_wp),
      .in_wn    (in_wn),
      .thr_hi   (thr_hi),
      .thr_lo   (thr_lo),
      .pc_a     (pc_a),
      .pc_cnt   (pc_cnt),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_act  (out_act),
      .out_sum  (out_sum),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      if (pc_a == 8'h00)
         pc_cnt = zero_bias ? 4'd2 : 4'd0;
      else
         pc_cnt = 4'($countones(pc_a));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a request at a negedge; returns 1 ns into cycle 1.
   task automatic issue(input logic [31:0] x, input logic [31:0] wp, input logic [31:0] wn,
                        input logic [6:0] hi, input logic [6:0] lo);
      @(negedge clk);
      in_x     = x;
      in_wp    = wp;
      in_wn    = wn;
      thr_hi   = hi;
      thr_lo   = lo;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_act !== 2'b00) begin bad++; $display("FAIL reset_out_act got=%b exp=00", out_act); end
      total++; if (out_sum !== 7'd0) begin bad++; $display("FAIL reset_out_sum got=%h exp=00", out_sum); end
      total++; if (pc_a !== 8'h00) begin bad++; $display("FAIL reset_pc_a got=%h exp=00", pc_a); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_release got_ready=%b got_busy=%b exp=1/0", in_ready, busy); end
   endtask

   task automatic test_positive();
      logic [7:0] exp_pc [8];
      exp_pc = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
      issue(32'hFFFFFFFF, 32'h0000FFFF, 32'h000000FF, 7'sd4, -7'sd4);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) step();
         total++; if (pc_a !== exp_pc[k]) begin bad++; $display("FAIL pos_pc_a cycle=%0d got=%h exp=%h", k + 1, pc_a, exp_pc[k]); end
         total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL pos_early cycle=%0d got_valid=%b got_busy=%b exp=0/1", k + 1, out_valid, busy); end
      end
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pos_valid_cycle9 got=%b exp=1", out_valid); end
      total++; if (out_sum !== 7'd8) begin bad++; $display("FAIL pos_sum got=%0d exp=8", $signed(out_sum)); end
      total++; if (out_act !== 2'b01) begin bad++; $display("FAIL pos_act got=%b exp=01", out_act); end
      total++; if (pc_a !== 8'h00) begin bad++; $display("FAIL pos_res_pc_a got=%h exp=00", pc_a); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL pos_handshake got_ready=%b got_valid=%b exp=1/0", in_ready, out_valid); end
   endtask

   task automatic test_negative();
      issue(32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 7'sd4, -7'sd4);
      repeat (8) step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL neg_valid got=%b exp=1", out_valid); end
      total++; if (out_sum !== 7'h60) begin bad++; $display("FAIL neg_sum got=%0d exp=-32", $signed(out_sum)); end
      total++; if (out_act !== 2'b11) begin bad++; $display("FAIL neg_act got=%b exp=11", out_act); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_zero_skip();
      logic [6:0] exp_sum;
      logic [1:0] exp_act;
`ifdef POPCOUNT_TN_ZERO_SKIP_EN
      exp_sum = 7'd8;
      exp_act = 2'b01;
`else
      exp_sum = 7'd6;
      exp_act = 2'b00;
`endif
      zero_bias = 1'b1;
      issue(32'h000000FF, 32'hFFFFFFFF, 32'h00000000, 7'sd7, -7'sd7);
      repeat (8) step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zskip_valid got=%b exp=1", out_valid); end
      total++; if (out_sum !== exp_sum) begin bad++; $display("FAIL zskip_sum got=%0d exp=%0d", $signed(out_sum), $signed(exp_sum)); end
      total++; if (out_act !== exp_act) begin bad++; $display("FAIL zskip_act got=%b exp=%b", out_act, exp_act); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      zero_bias = 1'b0;
   endtask

   task automatic test_backpressure();
      issue(32'hFFFFFFFF, 32'h0000FFFF, 32'h000000FF, 7'sd4, -7'sd4);
      repeat (8) step();
      in_x     = 32'hFFFFFFFF;
      in_wp    = 32'h00000000;
      in_wn    = 32'hFFFFFFFF;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         total++; if (out_valid !== 1'b1 || out_sum !== 7'd8 || out_act !== 2'b01) begin
            bad++; $display("FAIL bp_hold k=%0d got_valid=%b got_sum=%0d got_act=%b exp=1/8/01", k, out_valid, $signed(out_sum), out_act);
         end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready); end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release got_ready=%b got_busy=%b got_valid=%b exp=1/0/0", in_ready, busy, out_valid);
      end
   endtask

   task automatic test_mid_reset();
      logic saw_valid;
      issue(32'hFFFFFFFF, 32'h0000FFFF, 32'h000000FF, 7'sd4, -7'sd4);
      repeat (5) step();
      total++; if (busy !== 1'b1 || pc_a !== 8'h00) begin bad++; $display("FAIL mrst_pre got_busy=%b got_pc_a=%h exp=1/00", busy, pc_a); end
      #2;
      rst_n = 1'b0;
      #0.5;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b exp=0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
      total++; if (pc_a !== 8'h00 || out_valid !== 1'b0) begin bad++; $display("FAIL mrst_outputs got_pc_a=%h got_valid=%b exp=00/0", pc_a, out_valid); end
      #0.5;
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (6) begin
         step();
         if (out_valid === 1'b1) saw_valid = 1'b1;
      end
      total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL mrst_no_valid got=%b exp=0", saw_valid); end
      issue(32'hFFFFFFFF, 32'h0000FFFF, 32'h000000FF, 7'sd4, -7'sd4);
      repeat (7) step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_cycle8_valid got=%b exp=0", out_valid); end
      step();
      total++; if (out_valid !== 1'b1 || out_sum !== 7'd8 || out_act !== 2'b01) begin
         bad++; $display("FAIL mrst_after got_valid=%b got_sum=%0d got_act=%b exp=1/8/01", out_valid, $signed(out_sum), out_act);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      zero_bias = 1'b0;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_x      = '0;
      in_wp     = '0;
      in_wn     = '0;
      thr_hi    = '0;
      thr_lo    = '0;
      test_reset();
      test_positive();
      test_negative();
      test_zero_skip();
      test_backpressure();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/popcount_tn_seq.md
# popcount_tn_seq

Sequencer for a ternary-neuron evaluation that time-multiplexes one external 8-input approximate popcount unit (popcount08 family, 4-bit count output) over an `N_CHUNKS`×8-bit input vector. For each accepted request it counts the positive-weight matches, then the negative-weight matches, and accumulates both. It then forms the signed difference and thresholds it to a ternary activation. The block sits between the sensor-side input register and the neuron output stage, and owns the popcount unit's operand port.

## Interface
- `N_CHUNKS`, default 4: number of 8-bit chunks per input vector; must be ≥ 1.
- `ACC_W`, default 6: unsigned accumulator width; must satisfy ACC_W ≥ clog2(N_CHUNKS·15+1).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request; high only in IDLE.
- `in_x` in 8·N_CHUNKS: activation bits; chunk k is `[8k+7:8k]`.
- `in_wp` in 8·N_CHUNKS: positive-weight mask.
- `in_wn` in 8·N_CHUNKS: negative-weight mask.
- `thr_hi` in ACC_W+1: signed upper threshold.
- `thr_lo` in ACC_W+1: signed lower threshold.
- `pc_a` out 8: operand to the popcount unit.
- `pc_cnt` in 4: combinational count returned by the popcount unit for `pc_a` in the same cycle.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_act` out 2: ternary activation; 2'b01 = +1, 2'b11 = −1, 2'b00 = 0.
- `out_sum` out ACC_W+1: signed value acc_p − acc_n.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, POS, NEG, RES.
- IDLE, on `in_valid && in_ready`:
  - Latch `in_x`, `in_wp`, `in_wn`, `thr_hi`, `thr_lo`.
  - Clear `acc_p`, `acc_n` and the chunk index `idx`.
  - Go to POS.
- POS:
  - `pc_a` = x[idx] & wp[idx].
  - `acc_p` += `pc_cnt` (zero-extended).
  - If idx = N_CHUNKS−1: set idx to 0 and go to NEG. Otherwise increment idx.
- NEG:
  - `pc_a` = x[idx] & wn[idx].
  - `acc_n` += `pc_cnt`.
  - If idx = N_CHUNKS−1: go to RES. Otherwise increment idx.
- Entering RES:
  - Register `out_sum` = acc_p − acc_n, computed in ACC_W+1 signed.
  - Register `out_act`: +1 if sum ≥ thr_hi; else −1 if sum ≤ thr_lo; else 0. +1 has priority when thr_lo ≥ thr_hi.
- RES:
  - Hold `out_valid` = 1, with `out_sum` and `out_act` stable, until `out_ready` is high.
  - On that handshake go to IDLE.
- Outside POS and NEG, `pc_a` = 8'h00.
- `pc_cnt` is used as-is. The block does not correct approximation error, except as described under Configuration.
- Accumulators do not wrap: ACC_W sizing guarantees no overflow for any 4-bit `pc_cnt`.
- `in_valid` asserted outside IDLE is ignored; the request is not consumed.

## Timing
- Reset values: `in_ready` = 1, `busy` = 0, `out_valid` = 0, `out_act` = 2'b00, `out_sum` = 0, `pc_a` = 8'h00. State = IDLE, idx = 0, accumulators = 0.
- Accept edge = cycle 0.
- POS occupies cycles 1..N_CHUNKS.
- NEG occupies cycles N_CHUNKS+1..2·N_CHUNKS.
- `out_valid` rises at cycle 2·N_CHUNKS+1, i.e. cycle 9 for the default N_CHUNKS = 4.
- Latency is fixed and independent of data.
- `in_ready` returns high the cycle after the output handshake.
- Peak throughput: one result per 2·N_CHUNKS+2 cycles.
- `rst_n` asserted in any state (mid-POS, mid-NEG, or RES with `out_valid` high):
  - All outputs return to their reset values immediately, without waiting for `clk`.
  - The in-flight request is discarded.
  - The first request after reset release is processed correctly.

## Configuration
- `POPCOUNT_TN_ZERO_SKIP_EN` defined:
  - In POS and NEG, when the masked operand chunk is 8'h00, the accumulator adds 0 instead of `pc_cnt`.
  - This removes the nonzero bias the approximate units return for an all-zero input.
  - `pc_a` is still driven to 8'h00, and latency is unchanged.
- `POPCOUNT_TN_ZERO_SKIP_EN` undefined: `pc_cnt` is always accumulated.

## Test plan
All scenarios use N_CHUNKS = 4, ACC_W = 6. Unless stated, the bench popcount model is exact.
- **Reset:** assert `rst_n` = 0, then release. All outputs are at their reset values; `in_ready` = 1; `pc_a` = 8'h00.
- **Positive result:** x = 32'hFFFFFFFF, wp = 32'h0000FFFF, wn = 32'h000000FF, thr_hi = 4, thr_lo = −4.
  - `pc_a` sequence: FF, FF, 00, 00, FF, 00, 00, 00.
  - `out_valid` at cycle 9, `out_sum` = 8, `out_act` = 2'b01.
- **Negative result:** x = 32'hFFFFFFFF, wp = 0, wn = 32'hFFFFFFFF, thr_hi = 4, thr_lo = −4.
  - `out_sum` = −32, `out_act` = 2'b11.
- **Zero-skip:** bench model returns 2 for an input of 8'h00. x = 32'h000000FF, wp = 32'hFFFFFFFF, wn = 0, thr_hi = 7, thr_lo = −7.
  - Without the macro: `out_sum` = 6, `out_act` = 2'b00.
  - With the macro: `out_sum` = 8, `out_act` = 2'b01.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles after `out_valid` rises.
  - `out_valid`, `out_sum` and `out_act` stay stable; `in_ready` = 0.
  - A request offered during the stall is not accepted.
  - After the handshake, `in_ready` = 1 on the next cycle.
- **Mid-operation reset:** pulse `rst_n` low for 1 ns during the second NEG cycle.
  - `busy` drops and `in_ready` rises asynchronously; `out_valid` never asserts.
  - A new positive-result request afterwards yields `out_sum` = 8 at cycle 9.
